// File: rtl/rf_wb_arbiter.sv
// Writeback arbiter for the 16x16 register file: serialises load and ALU results
// onto one registered write port, buffering ALU results in a small circular FIFO.
module rf_wb_arbiter #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_valid,
  input  logic [3:0]                   alu_rd,
  input  logic [15:0]                  alu_data,
  output logic                         alu_ready,
  input  logic                         mem_valid,
  input  logic [3:0]                   mem_rd,
  input  logic [15:0]                  mem_data,
  output logic                         write_en,
  output logic [3:0]                   wr_rd,
  output logic [15:0]                  wr_data,
  output logic [15:0]                  pending_mask,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {SRC_NONE, SRC_MEM, SRC_FIFO, SRC_ALU} src_e;

  logic [3:0]            q_rd   [FIFO_DEPTH];
  logic [15:0]           q_data [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] q_vld;
  logic [PW-1:0]         rd_ptr, wr_ptr;
  logic [CW-1:0]         count;

  src_e        src;
  logic        alu_take, mem_take, fifo_empty, push, pop;
  logic [3:0]  issue_rd;
  logic [15:0] issue_data;

  // Readiness looks only at the registered count, so a full FIFO never pushes on pop.
  assign alu_ready  = !rst && (count < CW'(FIFO_DEPTH));
  assign alu_take   = alu_valid && alu_ready && (alu_rd != 4'd0);
  assign mem_take   = mem_valid && (mem_rd != 4'd0);
  assign fifo_empty = (count == '0);
  assign fifo_count = count;

  // NOTE: every always_comb output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    src        = SRC_NONE;
    issue_rd   = 4'd0;
    issue_data = 16'd0;
    if (mem_take) begin
      src        = SRC_MEM;
      issue_rd   = mem_rd;
      issue_data = mem_data;
    end else if (!fifo_empty) begin
      src        = SRC_FIFO;
      issue_rd   = q_rd[rd_ptr];
      issue_data = q_data[rd_ptr];
    end else if (alu_take) begin
      src        = SRC_ALU;
      issue_rd   = alu_rd;
      issue_data = alu_data;
    end
  end

  assign pop  = (src == SRC_FIFO);
  assign push = alu_take && (src != SRC_ALU);

  always_comb begin
    pending_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (q_vld[i]) pending_mask[q_rd[i]] = 1'b1;
    end
    pending_mask[0] = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      q_vld  <= '0;
    end else begin
      if (push) begin
        wr_ptr        <= wr_ptr + PW'(1);
        q_vld[wr_ptr] <= 1'b1;
      end
      if (pop) begin
        rd_ptr        <= rd_ptr + PW'(1);
        q_vld[rd_ptr] <= 1'b0;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array is not reset; the valid bits and count alone decide
  // which entries are live, so stale data is never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      q_rd[wr_ptr]   <= alu_rd;
      q_data[wr_ptr] <= alu_data;
    end
  end

  // Write address/data hold their last value on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      write_en <= 1'b0;
      wr_rd    <= 4'd0;
      wr_data  <= 16'd0;
    end else begin
      write_en <= (src != SRC_NONE);
      if (src != SRC_NONE) begin
        wr_rd   <= issue_rd;
        wr_data <= issue_data;
      end
    end
  end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter (FIFO_DEPTH = 2).
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [3:0]  alu_rd;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [3:0]  mem_rd;
  logic [15:0] mem_data;
  logic        write_en;
  logic [3:0]  wr_rd;
  logic [15:0] wr_data;
  logic [15:0] pending_mask;
  logic [1:0]  fifo_count;

  int errors = 0;
  int checks = 0;
  logic [3:0]  log_rd[$];
  logic [15:0] log_data[$];

  rf_wb_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_rd(mem_rd), .mem_data(mem_data),
    .write_en(write_en), .wr_rd(wr_rd), .wr_data(wr_data),
    .pending_mask(pending_mask), .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Advance to the next falling edge and record any register-file write seen there.
  task automatic step();
    @(negedge clk);
    if (write_en) begin
      log_rd.push_back(wr_rd);
      log_data.push_back(wr_data);
    end
  endtask

  task automatic idle();
    alu_valid = 1'b0; alu_rd = 4'd0; alu_data = 16'd0;
    mem_valid = 1'b0; mem_rd = 4'd0; mem_data = 16'd0;
  endtask

  task automatic clear_log();
    log_rd.delete();
    log_data.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    step();
    step();
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL reset_we: got %b expected 0", write_en); end
    checks++; if (wr_rd !== 4'd0) begin errors++; $display("FAIL reset_wr_rd: got %h expected 0", wr_rd); end
    checks++; if (wr_data !== 16'd0) begin errors++; $display("FAIL reset_wr_data: got %h expected 0000", wr_data); end
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", fifo_count); end
    checks++; if (pending_mask !== 16'h0000) begin errors++; $display("FAIL reset_mask: got %h expected 0000", pending_mask); end
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", alu_ready); end
    rst = 1'b0;
    #1;
    checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL first_ready: got %b expected 1", alu_ready); end
    clear_log();
  endtask

  task automatic test_bypass();
    alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 16'h1234;
    step();
    idle();
    checks++; if (write_en !== 1'b1) begin errors++; $display("FAIL bypass_we: got %b expected 1", write_en); end
    checks++; if (wr_rd !== 4'd3) begin errors++; $display("FAIL bypass_rd: got %0d expected 3", wr_rd); end
    checks++; if (wr_data !== 16'h1234) begin errors++; $display("FAIL bypass_data: got %h expected 1234", wr_data); end
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL bypass_count: got %0d expected 0", fifo_count); end
    step();
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL bypass_once: got %b expected 0", write_en); end
  endtask

  task automatic test_collision();
    mem_valid = 1'b1; mem_rd = 4'd5; mem_data = 16'hAAAA;
    alu_valid = 1'b1; alu_rd = 4'd5; alu_data = 16'h5555;
    step();
    idle();
    checks++; if (write_en !== 1'b1 || wr_rd !== 4'd5 || wr_data !== 16'hAAAA) begin errors++; $display("FAIL coll_t1: got we=%b rd=%0d data=%h expected we=1 rd=5 data=aaaa", write_en, wr_rd, wr_data); end
    checks++; if (pending_mask !== 16'h0020) begin errors++; $display("FAIL coll_mask_t1: got %h expected 0020", pending_mask); end
    step();
    checks++; if (write_en !== 1'b1 || wr_rd !== 4'd5 || wr_data !== 16'h5555) begin errors++; $display("FAIL coll_t2: got we=%b rd=%0d data=%h expected we=1 rd=5 data=5555", write_en, wr_rd, wr_data); end
    checks++; if (pending_mask !== 16'h0000) begin errors++; $display("FAIL coll_mask_t2: got %h expected 0000", pending_mask); end
    step();
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL coll_t3: got %b expected 0", write_en); end
  endtask

  task automatic test_fill_backpressure();
    logic [3:0]  exp_rd   [7] = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd1, 4'd2, 4'd3};
    logic [15:0] exp_data [7] = '{16'h0A00, 16'h0A01, 16'h0A02, 16'h0A03, 16'h0101, 16'h0102, 16'h0103};
    int k = 0;
    clear_log();
    for (int c = 0; c < 14; c++) begin
      mem_valid = (c < 4);
      mem_rd    = (c < 4) ? 4'(8 + c) : 4'd0;
      mem_data  = 16'h0A00 + 16'(c);
      alu_valid = (k < 3);
      alu_rd    = 4'(k + 1);
      alu_data  = 16'h0100 + 16'(k + 1);
      if (c == 2) begin
        checks++; if (k !== 2) begin errors++; $display("FAIL fill_accepted: got %0d expected 2", k); end
        checks++; if (alu_ready !== 1'b0 || fifo_count !== 2'd2) begin errors++; $display("FAIL fill_full: got ready=%b count=%0d expected ready=0 count=2", alu_ready, fifo_count); end
      end
      if (alu_valid && alu_ready) k++;
      step();
    end
    idle();
    checks++; if (log_rd.size() !== 7) begin errors++; $display("FAIL fill_nwrites: got %0d expected 7", log_rd.size()); end
    for (int i = 0; i < 7 && i < log_rd.size(); i++) begin
      checks++; if (log_rd[i] !== exp_rd[i] || log_data[i] !== exp_data[i]) begin errors++; $display("FAIL fill_write%0d: got rd=%0d data=%h expected rd=%0d data=%h", i, log_rd[i], log_data[i], exp_rd[i], exp_data[i]); end
    end
  endtask

  task automatic test_r0_discard();
    alu_valid = 1'b1; alu_rd = 4'd0; alu_data = 16'hFFFF;
    mem_valid = 1'b1; mem_rd = 4'd0; mem_data = 16'hBEEF;
    step();
    idle();
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL r0_we: got %b expected 0", write_en); end
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL r0_count: got %0d expected 0", fifo_count); end
    checks++; if (pending_mask !== 16'h0000) begin errors++; $display("FAIL r0_mask: got %h expected 0000", pending_mask); end
    step();
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL r0_late_we: got %b expected 0", write_en); end
  endtask

  task automatic test_pointer_wrap();
    int k = 0;
    int mem_sent = 0;
    int max_count = 0;
    int alu_seen = 0;
    int mem_seen = 0;
    clear_log();
    for (int c = 0; c < 40; c++) begin
      mem_valid = (c % 2 == 1) && (c < 30);
      mem_rd    = 4'd15;
      mem_data  = 16'hF000 + 16'(c);
      alu_valid = (k < 10);
      alu_rd    = 4'(k + 1);
      alu_data  = 16'h0200 + 16'(k + 1);
      if (mem_valid) mem_sent++;
      if (alu_valid && alu_ready) k++;
      step();
      if (int'(fifo_count) > max_count) max_count = int'(fifo_count);
    end
    idle();
    checks++; if (k !== 10) begin errors++; $display("FAIL wrap_accepted: got %0d expected 10", k); end
    checks++; if (max_count > 2) begin errors++; $display("FAIL wrap_max_count: got %0d expected <= 2", max_count); end
    for (int i = 0; i < log_rd.size(); i++) begin
      if (log_rd[i] == 4'd15) begin
        mem_seen++;
      end else begin
        alu_seen++;
        checks++; if (log_rd[i] !== 4'(alu_seen) || log_data[i] !== 16'h0200 + 16'(alu_seen)) begin errors++; $display("FAIL wrap_order%0d: got rd=%0d data=%h expected rd=%0d data=%h", alu_seen, log_rd[i], log_data[i], alu_seen, 16'h0200 + 16'(alu_seen)); end
      end
    end
    checks++; if (alu_seen !== 10) begin errors++; $display("FAIL wrap_alu_writes: got %0d expected 10", alu_seen); end
    checks++; if (mem_seen !== mem_sent) begin errors++; $display("FAIL wrap_mem_writes: got %0d expected %0d", mem_seen, mem_sent); end
  endtask

  task automatic test_reset_mid();
    mem_valid = 1'b1; mem_rd = 4'd12; mem_data = 16'h0C00;
    alu_valid = 1'b1; alu_rd = 4'd6;  alu_data = 16'h0606;
    step();
    mem_rd = 4'd13; mem_data = 16'h0D00;
    alu_rd = 4'd7;  alu_data = 16'h0707;
    step();
    idle();
    checks++; if (fifo_count !== 2'd2) begin errors++; $display("FAIL mid_count_before: got %0d expected 2", fifo_count); end
    checks++; if (pending_mask !== 16'h00C0) begin errors++; $display("FAIL mid_mask_before: got %h expected 00c0", pending_mask); end
    rst = 1'b1;
    #1;
    checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL mid_ready_in_reset: got %b expected 0", alu_ready); end
    step();
    rst = 1'b0;
    checks++; if (write_en !== 1'b0) begin errors++; $display("FAIL mid_we: got %b expected 0", write_en); end
    checks++; if (fifo_count !== 2'd0) begin errors++; $display("FAIL mid_count: got %0d expected 0", fifo_count); end
    checks++; if (pending_mask !== 16'h0000) begin errors++; $display("FAIL mid_mask: got %h expected 0000", pending_mask); end
    clear_log();
    repeat (5) step();
    checks++; if (log_rd.size() !== 0) begin errors++; $display("FAIL mid_no_writes: got %0d writes expected 0", log_rd.size()); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_collision();
    test_fill_backpressure();
    test_r0_discard();
    test_pointer_wrap();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Writeback arbiter that drives the single write port of the 16x16 register file. It accepts results from two producers: the ALU and the data-memory load path. It serialises them onto one registered write per cycle and buffers ALU results in a small FIFO when a load wins the port. It also exports a pending-destination mask so issue logic can detect read-after-write hazards on results that are still buffered.

## Interface
Parameters:
- FIFO_DEPTH, 2, number of ALU result entries buffered. Must be a power of 2 and at least 2.

Ports:
- clk, input, 1, system clock. All state updates on the rising edge.
- rst, input, 1, reset. Synchronous, active-high.
- alu_valid, input, 1, ALU result present this cycle.
- alu_rd, input, 4, ALU destination register.
- alu_data, input, 16, ALU result.
- alu_ready, output, 1, ALU result accepted when alu_valid and alu_ready are both high.
- mem_valid, input, 1, load result present this cycle. Always accepted; the memory path never stalls.
- mem_rd, input, 4, load destination register.
- mem_data, input, 16, load data.
- write_en, output, 1, register-file write strobe.
- wr_rd, output, 4, register-file write address.
- wr_data, output, 16, register-file write data.
- pending_mask, output, 16, bit i is high while any FIFO entry targets r[i].
- fifo_count, output, clog2(FIFO_DEPTH)+1, number of occupied FIFO entries.

## Operation
- A result with rd = 0 is accepted and then discarded. It is never enqueued, never issued, and never sets pending_mask[0], so pending_mask[0] is always 0.
- Each cycle at most one result is issued. Priority order:
  1. mem (mem_valid with mem_rd != 0).
  2. FIFO head, which is popped.
  3. ALU bypass, only when the FIFO is empty and an ALU result is accepted with alu_rd != 0.
- An accepted ALU result with rd != 0 that is not issued by bypass is pushed to the FIFO tail.
- alu_ready = !rst && (fifo_count < FIFO_DEPTH). It is computed from registered count only, so there is no push-on-pop when full: a full FIFO deasserts alu_ready even in a cycle where it pops.
- Issue order follows acceptance order within the ALU stream. Mem results may overtake buffered ALU results.
- Same rd from mem and ALU in the same cycle: mem is written first and the ALU value is written later, so the ALU value is final.
- The FIFO is a circular buffer. Read and write pointers wrap modulo FIFO_DEPTH, and a separate count distinguishes full from empty.
- pending_mask is combinational from FIFO contents. A bit clears in the cycle after its entry pops.

## Timing
- Outputs write_en, wr_rd and wr_data are registered. A result issued in cycle T appears with write_en = 1 during T+1, for exactly one cycle per issued result.
- When nothing is issued, write_en = 0 and wr_rd/wr_data hold their previous values.
- Latency:
  - mem: 1 cycle.
  - ALU bypass: 1 cycle.
  - Buffered ALU: 1 cycle after the cycle it reaches the head with no mem competing.
- Reset (rst high at a clock edge):
  - write_en = 0, wr_rd = 0, wr_data = 0.
  - FIFO emptied, fifo_count = 0, pending_mask = 0.
  - alu_ready = 0 while rst is high.
  - Inputs are ignored in reset cycles.
  - Reset mid-operation discards all buffered results with no write issued.
- First acceptance is possible in the first cycle with rst low. alu_ready = 1 in that cycle.
- Continuous mem traffic starves the FIFO indefinitely. The memory path must leave gaps; no starvation guard is provided.

## Test plan
- Bypass: reset, then alu_valid with rd = 3, data = 0x1234, no mem. Required: write_en = 1, wr_rd = 3, wr_data = 0x1234 exactly one cycle later, and fifo_count stays 0.
- Collision: same cycle, mem rd = 5 / 0xAAAA and ALU rd = 5 / 0x5555. Required:
  - T+1: write 5 = 0xAAAA.
  - T+2: write 5 = 0x5555.
  - pending_mask = 0x0020 during T+1 only.
- Fill and backpressure (FIFO_DEPTH = 2): hold mem_valid for 4 cycles while presenting ALU rd = 1, 2, 3. Required:
  - rd 1 and 2 are accepted.
  - alu_ready = 0 with fifo_count = 2, so rd 3 is held.
  - After mem stops, writes appear in order 1, 2, 3 with no loss and no duplication.
- r0 discard: ALU rd = 0 / 0xFFFF and mem rd = 0 / 0xBEEF. Required: no write_en, fifo_count = 0, pending_mask = 0.
- Pointer wrap: stream 10 ALU results rd = 1..10 while mem alternates valid on odd cycles. Required: all 10 are written in order, and fifo_count never exceeds 2.
- Reset mid-operation: with 2 entries buffered, assert rst for 1 cycle. Required:
  - Next cycle: write_en = 0, fifo_count = 0, pending_mask = 0.
  - Buffered results are never written.
